branch_resolve_unit: RTL
========================

# branch_resolve_unit

- Feedback end of the branch prediction path: records each fetched branch's prediction in an in-order queue, then checks the oldest entry against the outcome resolved in EX.
- Produces the one-cycle `PreRight`/`PreWrong` pulses that train the 2-bit predictor.
- On a misprediction, produces the pipeline flush and the redirect PC.
- Sits between the IF-stage predictor/fetch logic and the EX-stage branch comparator.

## Interface
- `ADDR_W`, 32, PC width.
- `DEPTH`, 4, in-flight branch capacity; power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  pipeline stall; freezes block, same stall as the predictor.
- `push`  in  1  IF fetched a branch; record it this cycle.
- `push_pre`  in  1  prediction for that branch (`BrPre`; 1 = taken).
- `push_alt_pc`  in  ADDR_W  PC to fetch if the prediction is wrong: fall-through if predicted taken, target if predicted not-taken.
- `resolve`  in  1  EX resolved the oldest in-flight branch.
- `resolve_taken`  in  1  actual outcome (1 = taken).
- `PreRight`  out  1  one-cycle pulse: oldest prediction correct.
- `PreWrong`  out  1  one-cycle pulse: oldest prediction wrong.
- `flush`  out  1  one-cycle pulse: kill younger instructions.
- `redirect_pc`  out  ADDR_W  fetch target; valid only while `flush`=1.
- `full`  out  1  DEPTH entries held.
- `empty`  out  1  no entries held.
- `proto_err`  out  1  sticky flag; set by push-when-full or resolve-when-empty.

## Operation
- Queue entry = {pre, alt_pc}.
  - Accepted push writes at wptr.
  - Accepted resolve reads/pops at rptr.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
  - full/empty decoded from MSB/LSB pointer compare.
- FSM states:
  - NORMAL: push/resolve accepted when `stall`=0.
  - FLUSH: lasts exactly one cycle after a mispredict. `flush`=1 and all push/resolve are ignored (they are wrong-path). Then returns to NORMAL.
- Resolve with stored pre == `resolve_taken`: pulse `PreRight`, pop the entry, stay in NORMAL.
- Resolve with stored pre != `resolve_taken`:
  - pulse `PreWrong`;
  - load `redirect_pc` from the entry's alt_pc;
  - clear the whole queue (rptr=wptr=0), since younger entries are wrong-path;
  - enter FLUSH.
- Same-cycle push+resolve:
  - Correct resolve: both take effect; allowed while full, because the pop frees a slot.
  - Mispredict: the push is discarded.
- Push while full with no same-cycle pop: push dropped, `proto_err` set.
- Resolve while empty: ignored, `proto_err` set.
- `stall`=1: no push, no pop, no FSM transition; pulse outputs are 0 in the following cycle. A pending FLUSH state holds `flush`/`redirect_pc` until the cycle after stall drops.
- `PreRight` and `PreWrong` are never both 1.
- Reset values:
  - state NORMAL;
  - pointers 0;
  - `PreRight`/`PreWrong`/`flush`/`proto_err` = 0;
  - `redirect_pc` = 0;
  - `empty`=1, `full`=0.
- Reset mid-operation discards all entries and any pending flush immediately.

## Timing
- All outputs are registered.
- Resolve sampled at edge t → `PreRight`/`PreWrong`/`flush`/`redirect_pc` valid during cycle t+1, for one cycle.
- The predictor consumes the pulse at edge t+2.
- Push at edge t → entry visible to resolve from edge t+1. A resolve in the same cycle as a push into an empty queue is a resolve-when-empty.
- `full`/`empty` reflect pointers after edge t.

## Configuration
- Macro `BR_RESOLVE_STATS_EN`.
- Defined: adds outputs `br_cnt` (32) and `miss_cnt` (32).
  - `br_cnt` increments per accepted resolve; `miss_cnt` increments per mispredict.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `br_pkg` holds:
  - FSM state enum (NORMAL, FLUSH);
  - entry struct typedef {pre, alt_pc};
  - default DEPTH/ADDR_W constants.
- One sub-module, `br_fifo`: parameterised queue with push/pop/clear, full/empty. Owns no compare logic.

## Test plan
- Reset, push pre=1 alt=0x100, resolve taken=1 → `PreRight`=1 one cycle later for one cycle, `flush`=0, `empty`=1.
- Push pre=1 alt=0x40, push pre=0 alt=0x80, resolve taken=0 → `PreWrong`=1, `flush`=1, `redirect_pc`=0x40, `empty`=1; push in the FLUSH cycle ignored.
- Fill 4 entries, push+correct resolve same cycle → `full` stays 1, `proto_err`=0. Push alone while full → `proto_err`=1.
- Mispredict resolve with `stall`=1 for 3 cycles afterward → `flush` held; queue frozen; pulses occur once, after release.
- Assert `rst_n`=0 while in FLUSH → `flush`=0 and `empty`=1 immediately, without waiting for a clock edge.
- With `BR_RESOLVE_STATS_EN`: 10 resolves, 3 wrong → `br_cnt`=10, `miss_cnt`=3.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and defaults for the branch resolve unit: FSM state, queue entry layout.
package br_pkg;

    localparam int BR_ADDR_W = 32;
    localparam int BR_DEPTH  = 4;

    typedef enum logic {
        NORMAL = 1'b0,
        FLUSH  = 1'b1
    } br_state_e;

    typedef struct packed {
        logic                 pre;
        logic [BR_ADDR_W-1:0] alt_pc;
    } br_entry_t;

endpackage

// File: rtl/branch_resolve_unit_fifo.sv
// In-order queue of in-flight branch predictions with push/pop/clear and full/empty.
module br_fifo
    import br_pkg::*;
#(
    parameter int DEPTH  = BR_DEPTH,
    parameter int DATA_W = BR_ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    input  logic              clear,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;

    // Extra pointer MSB distinguishes a full queue from an empty one.
    assign empty = (wptr == rptr);
    assign full  = (wptr[PW-1] != rptr[PW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Checks the oldest queued branch prediction against the EX outcome; trains and redirects.
// Optional stats counters (br_cnt, miss_cnt) are enabled by defining BR_RESOLVE_STATS_EN.
module branch_resolve_unit
    import br_pkg::*;
#(
    parameter int ADDR_W = BR_ADDR_W,
    parameter int DEPTH  = BR_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              push,
    input  logic              push_pre,
    input  logic [ADDR_W-1:0] push_alt_pc,
    input  logic              resolve,
    input  logic              resolve_taken,
    output logic              PreRight,
    output logic              PreWrong,
    output logic              flush,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              full,
    output logic              empty,
    output logic              proto_err
`ifdef BR_RESOLVE_STATS_EN
    ,
    output logic [31:0]       br_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    br_state_e         state;
    logic [ADDR_W:0]   head;
    logic              head_pre;
    logic [ADDR_W-1:0] head_alt_pc;
    logic              active;
    logic              res_ok;
    logic              hit;
    logic              miss;
    logic              push_ok;
    logic              push_err;
    logic              res_err;

    assign head_pre    = head[ADDR_W];
    assign head_alt_pc = head[ADDR_W-1:0];

    // Everything arriving in the FLUSH cycle is wrong-path and is dropped silently.
    assign active   = !stall && (state == NORMAL);
    assign res_ok   = active && resolve && !empty;
    assign hit      = res_ok && (head_pre == resolve_taken);
    assign miss     = res_ok && (head_pre != resolve_taken);
    assign push_ok  = active && push && !miss && (!full || hit);
    assign push_err = active && push && full && !res_ok;
    assign res_err  = active && resolve && empty;

    br_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ADDR_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok),
        .wdata ({push_pre, push_alt_pc}),
        .pop   (hit),
        .clear (miss),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= NORMAL;
            PreRight    <= 1'b0;
            PreWrong    <= 1'b0;
            flush       <= 1'b0;
            redirect_pc <= '0;
            proto_err   <= 1'b0;
        end else begin
            PreRight <= hit;
            PreWrong <= miss;
            if (push_err || res_err) proto_err <= 1'b1;
            if (!stall) begin
                case (state)
                    NORMAL: begin
                        if (miss) begin
                            state       <= FLUSH;
                            flush       <= 1'b1;
                            redirect_pc <= head_alt_pc;
                        end
                    end
                    FLUSH: begin
                        state <= NORMAL;
                        flush <= 1'b0;
                    end
                    default: begin
                        state <= NORMAL;
                        flush <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef BR_RESOLVE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt   <= '0;
            miss_cnt <= '0;
        end else begin
            if (res_ok && (br_cnt != '1))  br_cnt   <= br_cnt + 32'd1;
            if (miss && (miss_cnt != '1))  miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule
